// File: rtl/fp_round_pipe.sv
// Two-stage rounder/normaliser for the FPU add/sub path: stage 1 normalises and picks the round increment, stage 2 applies it.
// Latency 2 cycles, 1 result/cycle; a stalled output holds both stages and drops in_ready, never losing or repeating a result.
module fp_round_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_frm,
  input  logic                   in_sign,
  input  logic [EXP_W+1:0]       in_exp,
  input  logic [MAN_W+4:0]       in_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_fp,
  output logic [4:0]             out_flags
);

  localparam int FP_W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] FRM_RNE = 3'b000;
  localparam logic [2:0] FRM_RZE = 3'b001;
  localparam logic [2:0] FRM_RDN = 3'b010;
  localparam logic [2:0] FRM_RUP = 3'b011;
  localparam logic [2:0] FRM_RMM = 3'b100;

  localparam logic [EXP_W+1:0] EXP_ONE  = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic [EXP_W+1:0] EXP_INF  = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EXP_W+1:0] EXP_MAXF = EXP_INF - EXP_ONE;

  localparam logic [FP_W-2:0] MAG_QNAN = {{EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [FP_W-2:0] MAG_INF  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [FP_W-2:0] MAG_MAXF = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  typedef struct packed {
    logic              sign;
    logic [EXP_W+1:0]  exp;
    logic [MAN_W:0]    sig;        // {hidden, fraction} after normalisation
    logic              inc;
    logic              nx;
    logic              inf_mode;   // overflow goes to infinity rather than max finite
    logic              dir_ovf;    // truncating mode, exact value already above max finite
    logic              bypass;
    logic [FP_W-1:0]   byp_fp;
    logic [4:0]        byp_flags;
  } s1_t;

  // Exponent headroom saturates instead of wrapping.
  function automatic logic [EXP_W+1:0] sat_inc(input logic [EXP_W+1:0] e);
    return (&e) ? e : e + EXP_ONE;
  endfunction

  logic s1_valid;
  s1_t  s1_q;
  s1_t  s1_d;
  logic s1_load;
  logic s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // ---------------- stage 1: normalise and decide ----------------
  logic             carry;
  logic             g;
  logic             r;
  logic             s;
  logic             t;
  logic             l;
  logic             inc;
  logic             directed;
  logic [MAN_W:0]   sig_n;
  logic [EXP_W+1:0] exp_n;

  always_comb begin
    carry    = in_mant[MAN_W+4];
    sig_n    = in_mant[MAN_W+3:3];
    g        = in_mant[2];
    r        = in_mant[1];
    s        = in_mant[0];
    exp_n    = in_exp;
    inc      = 1'b0;
    directed = 1'b0;
    s1_d     = '0;

    if (carry) begin
      sig_n = in_mant[MAN_W+4:4];
      g     = in_mant[3];
      r     = in_mant[2];
      s     = in_mant[1] | in_mant[0];
      exp_n = sat_inc(in_exp);
    end

    t = r | s;
    l = sig_n[0];

    case (in_frm)
      FRM_RNE: inc = g & (t | l);
      FRM_RZE: inc = 1'b0;
      FRM_RDN: inc = in_sign & (g | t);
      FRM_RUP: inc = !in_sign & (g | t);
      FRM_RMM: inc = g;
      default: inc = 1'b0;
    endcase

    directed = (in_frm == FRM_RZE) || (in_frm == FRM_RDN) || (in_frm == FRM_RUP);

    s1_d.sign     = in_sign;
    s1_d.exp      = exp_n;
    s1_d.sig      = sig_n;
    s1_d.inc      = inc;
    s1_d.nx       = g | t;
    s1_d.inf_mode = (in_frm == FRM_RNE) || (in_frm == FRM_RMM) ||
                    ((in_frm == FRM_RDN) && in_sign) || ((in_frm == FRM_RUP) && !in_sign);
    s1_d.dir_ovf  = directed && (exp_n == EXP_MAXF) && (&sig_n) && (g | t);

    if (in_frm > FRM_RMM) begin
      s1_d.bypass    = 1'b1;
      s1_d.byp_fp    = {1'b0, MAG_QNAN};
      s1_d.byp_flags = 5'b10000;
    end else if (in_mant[MAN_W+4:3] == '0) begin
      s1_d.bypass    = 1'b1;
      s1_d.byp_fp    = {in_sign, {(FP_W-1){1'b0}}};
      s1_d.byp_flags = 5'b00000;
    end
  end

  // ---------------- stage 2: apply increment, overflow, pack ----------------
  logic [MAN_W+1:0] sum;
  logic             rcarry;
  logic [EXP_W+1:0] exp_r;
  logic             subn;
  logic             ovf;
  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] frac_r;
  logic [FP_W-1:0]  res_fp;
  logic [4:0]       res_flags;

  always_comb begin
    sum       = {1'b0, s1_q.sig} + {{(MAN_W+1){1'b0}}, s1_q.inc};
    rcarry    = sum[MAN_W+1];
    exp_r     = rcarry ? sat_inc(s1_q.exp) : s1_q.exp;
    subn      = (s1_q.exp == '0);
    ovf       = (exp_r >= EXP_INF) || s1_q.dir_ovf;
    frac_r    = rcarry ? '0 : sum[MAN_W-1:0];
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    exp_field = subn ? {{(EXP_W-1){1'b0}}, sum[MAN_W]} : exp_r[EXP_W-1:0];
    res_fp    = {s1_q.sign, exp_field, frac_r};
    res_flags = {3'b000, subn & s1_q.nx, s1_q.nx};

    if (s1_q.bypass) begin
      res_fp    = s1_q.byp_fp;
      res_flags = s1_q.byp_flags;
    end else if (ovf) begin
      res_fp    = {s1_q.sign, s1_q.inf_mode ? MAG_INF : MAG_MAXF};
      res_flags = 5'b00101;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      out_fp    <= '0;
      out_flags <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_fp    <= res_fp;
          out_flags <= res_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe (EXP_W=8, MAN_W=23): directed table, backpressure and reset sequences, random stream vs reference model.
module tb_fp_round_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_frm;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fp;
  logic [4:0]  out_flags;

  always #5 CLK = ~CLK;

  fp_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_frm    (in_frm),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp),
    .out_flags (out_flags)
  );

  typedef struct {
    logic [2:0]  frm;
    logic        sign;
    logic [9:0]  ex;
    logic [27:0] mt;
    logic [31:0] fp;
    logic [4:0]  fl;
  } vec_t;

  typedef struct {
    logic [31:0] fp;
    logic [4:0]  fl;
    int          tag;
  } pend_t;

  vec_t        vecs[17];
  vec_t        bp[3];
  vec_t        vz;
  pend_t       q[$];
  int          errors = 0;
  int          checks = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] hold_fp;
  logic [4:0]  hold_fl;
  logic        acc;

  // Reference: treat the mantissa as an integer, compare the discarded remainder against half an ulp.
  function automatic logic [36:0] ref_round(input logic [2:0] frm, input logic sg,
                                            input logic [9:0] ex, input logic [27:0] mt);
    longint sig, keep, keep_pre, rem;
    int     e, e_pre;
    bit     up, nx, ovf, nearest, exceeds, to_inf;
    logic [31:0] fp;
    logic [4:0]  fl;
    if (frm > 3'd4) return {32'h7FC00000, 5'b10000};
    if (mt[27:3] == 25'd0) return {sg, 31'd0, 5'd0};
    sig = longint'(mt);
    e   = int'(ex);
    if (sig >= (longint'(1) << 27)) begin
      sig = (sig >> 1) | (sig & 1);
      if (e < 1023) e = e + 1;
    end
    keep = sig >> 3;
    rem  = sig & 7;
    nx   = (rem != 0);
    case (frm)
      3'd0:    up = (rem > 4) || (rem == 4 && (keep & 1) == 1);
      3'd1:    up = 1'b0;
      3'd2:    up = sg && nx;
      3'd3:    up = !sg && nx;
      default: up = (rem >= 4);
    endcase
    e_pre    = e;
    keep_pre = keep;
    if (up) keep = keep + 1;
    if (keep == (longint'(1) << 24)) begin
      keep = longint'(1) << 23;
      if (e < 1023) e = e + 1;
    end
    nearest = (frm == 3'd0) || (frm == 3'd4);
    exceeds = (e_pre > 254) || (e_pre == 254 && keep_pre == 64'hFFFFFF && nx);
    ovf     = nearest ? (e >= 255) : exceeds;
    if (ovf) begin
      to_inf = nearest || (frm == 3'd2 && sg) || (frm == 3'd3 && !sg);
      fp = to_inf ? {sg, 8'hFF, 23'h0} : {sg, 8'hFE, 23'h7FFFFF};
      fl = 5'b00101;
    end else if (e_pre == 0) begin
      fp = {sg, 8'(keep >> 23), 23'(keep)};
      fl = {3'b000, nx, nx};
    end else begin
      fp = {sg, 8'(e), 23'(keep)};
      fl = {4'b0000, nx};
    end
    return {fp, fl};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // One clock: drive at negedge, then observe the handshakes that the coming posedge will perform.
  task automatic cycle(input logic iv, input vec_t v, input int tag, input logic ordy, output logic a);
    pend_t p;
    @(negedge CLK);
    in_valid  = iv;
    in_frm    = v.frm;
    in_sign   = v.sign;
    in_exp    = v.ex;
    in_mant   = v.mt;
    out_ready = ordy;
    #1;
    if (stall_prev) begin
      checks++;
      if (out_valid !== 1'b1 || out_fp !== hold_fp || out_flags !== hold_fl) begin
        errors++;
        $display("FAIL hold_stable got valid=%b fp=%h flags=%b want valid=1 fp=%h flags=%b",
                 out_valid, out_fp, out_flags, hold_fp, hold_fl);
      end
    end
    stall_prev = out_valid && !out_ready;
    hold_fp    = out_fp;
    hold_fl    = out_flags;
    if (out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got fp=%h flags=%b want no output", out_fp, out_flags);
      end else begin
        p = q.pop_front();
        if (out_fp !== p.fp || out_flags !== p.fl) begin
          errors++;
          $display("FAIL result tag=%0d got fp=%h flags=%b want fp=%h flags=%b",
                   p.tag, out_fp, out_flags, p.fp, p.fl);
        end
      end
    end
    a = iv && in_ready;
    if (a) begin
      p.fp  = v.fp;
      p.fl  = v.fl;
      p.tag = tag;
      q.push_back(p);
    end
  endtask

  task automatic drain();
    logic a;
    for (int k = 0; k < 100 && q.size() > 0; k++) cycle(1'b0, vz, 0, 1'b1, a);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int   sel;
    v.frm  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
    v.sign = 1'($urandom);
    sel = $urandom_range(0, 15);
    case (sel)
      0:       v.ex = 10'd0;
      1:       v.ex = 10'd254;
      2:       v.ex = 10'd255;
      3:       v.ex = 10'($urandom_range(256, 1023));
      4:       v.ex = 10'd1023;
      default: v.ex = 10'($urandom_range(1, 253));
    endcase
    v.mt = 28'($urandom);
    sel = $urandom_range(0, 7);
    if (sel == 0) v.mt[25:3] = '1;
    else if (sel == 1) v.mt[27:3] = '0;
    else if (sel == 2) v.mt[27] = 1'b0;
    if (v.ex == 10'd0 && !v.mt[27]) v.mt[26] = 1'b0;
    {v.fp, v.fl} = ref_round(v.frm, v.sign, v.ex, v.mt);
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   k;
    vecs[0]  = '{3'd0, 1'b0, 10'h07F, {1'b0, 1'b1, 23'h000001, 3'b100}, 32'h3F800002, 5'b00001};
    vecs[1]  = '{3'd0, 1'b0, 10'h07F, {1'b0, 1'b1, 23'h000000, 3'b100}, 32'h3F800000, 5'b00001};
    vecs[2]  = '{3'd0, 1'b0, 10'h07F, {1'b1, 1'b1, 23'h7FFFFF, 3'b111}, 32'h40800000, 5'b00001};
    vecs[3]  = '{3'd0, 1'b0, 10'h0FE, {1'b0, 1'b1, 23'h7FFFFF, 3'b100}, 32'h7F800000, 5'b00101};
    vecs[4]  = '{3'd1, 1'b0, 10'h0FE, {1'b0, 1'b1, 23'h7FFFFF, 3'b100}, 32'h7F7FFFFF, 5'b00101};
    vecs[5]  = '{3'd2, 1'b1, 10'h0FE, {1'b0, 1'b1, 23'h7FFFFF, 3'b100}, 32'hFF800000, 5'b00101};
    vecs[6]  = '{3'd5, 1'b0, 10'h07F, {1'b0, 1'b1, 23'h123456, 3'b010}, 32'h7FC00000, 5'b10000};
    vecs[7]  = '{3'd7, 1'b1, 10'h001, {1'b1, 1'b0, 23'h000000, 3'b000}, 32'h7FC00000, 5'b10000};
    vecs[8]  = '{3'd0, 1'b1, 10'h055, {1'b0, 1'b0, 23'h000000, 3'b111}, 32'h80000000, 5'b00000};
    vecs[9]  = '{3'd3, 1'b0, 10'h07F, {1'b0, 1'b1, 23'h123456, 3'b000}, 32'h3F923456, 5'b00000};
    vecs[10] = '{3'd3, 1'b0, 10'h07F, {1'b0, 1'b1, 23'h000000, 3'b001}, 32'h3F800001, 5'b00001};
    vecs[11] = '{3'd2, 1'b0, 10'h07F, {1'b0, 1'b1, 23'h000000, 3'b001}, 32'h3F800000, 5'b00001};
    vecs[12] = '{3'd4, 1'b0, 10'h07F, {1'b0, 1'b1, 23'h000002, 3'b100}, 32'h3F800003, 5'b00001};
    vecs[13] = '{3'd0, 1'b0, 10'h000, {1'b0, 1'b0, 23'h7FFFFF, 3'b100}, 32'h00800000, 5'b00011};
    vecs[14] = '{3'd0, 1'b0, 10'h000, {1'b0, 1'b0, 23'h000010, 3'b000}, 32'h00000010, 5'b00000};
    vecs[15] = '{3'd3, 1'b1, 10'h0FE, {1'b0, 1'b1, 23'h7FFFFF, 3'b100}, 32'hFF7FFFFF, 5'b00101};
    vecs[16] = '{3'd0, 1'b0, 10'h300, {1'b0, 1'b1, 23'h000000, 3'b000}, 32'h7F800000, 5'b00101};
    vz = '{3'd0, 1'b0, 10'd0, 28'd0, 32'd0, 5'd0};

    RST = 1'b1; in_valid = 1'b0; in_frm = 3'd0; in_sign = 1'b0;
    in_exp = '0; in_mant = '0; out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_fp", 64'(out_fp), 64'd0);
    chk("reset_out_flags", 64'(out_flags), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, back to back.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, vecs[i], i, 1'b1, acc);
      chk("dir_accept", 64'(acc), 64'd1);
    end
    drain();

    // Backpressure: four stalled cycles with three offers.
    bp[0] = vecs[9]; bp[1] = vecs[12]; bp[2] = vecs[0];
    k = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(k < 3, (k < 3) ? bp[k] : vz, 800 + k, 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < 10 && k < 3; c++) begin
      cycle(1'b1, bp[k], 800 + k, 1'b1, acc);
      if (acc) k++;
    end
    chk("bp_third", 64'(k), 64'd3);
    drain();

    // Reset with both stages occupied.
    cycle(1'b1, vecs[3], 900, 1'b0, acc);
    cycle(1'b1, vecs[4], 901, 1'b0, acc);
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("pre_reset_full_out_valid", 64'(out_valid), 64'd1);
    chk("pre_reset_full_in_ready", 64'(in_ready), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_out_flags", 64'(out_flags), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    stall_prev = 1'b0;
    repeat (4) cycle(1'b0, vz, 0, 1'b1, acc);
    chk("rst_mid_nothing_emitted", 64'(out_valid), 64'd0);

    // Random stream with random backpressure.
    for (int n = 0; n < 400; n++) begin
      v = rand_vec();
      acc = 1'b0;
      for (int g = 0; g < 50 && !acc; g++)
        cycle(1'b1, v, 1000 + n, ($urandom_range(0, 9) < 7), acc);
      if (!acc) begin
        checks++; errors++;
        $display("FAIL rand_accept tag=%0d got no accept want accept within 50 cycles", 1000 + n);
      end
      if ($urandom_range(0, 3) == 0) cycle(1'b0, vz, 0, ($urandom_range(0, 9) < 7), acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
